// File: rtl/hazard_ctrl_mc.sv
// hazard_ctrl_mc: pipeline hazard controller for a 5-stage core with a multi-cycle
// divider, a variable-latency data-memory handshake and precise exceptions taken in M.
//
// Optional feature macro: HAZARD_FWD_E2D_EN
//   defined   -> E result forwarded into D (forwardaD/bD code 01); branch compares no
//                longer stall on non-load E writers.
//   undefined -> no E->D path; a branch in D stalls on any E writer of a used source.
//
// Ports
//   clk, resetn                 clock, asynchronous active-low reset
//   rsD, rtD, use_rsD, use_rtD  D-stage sources and whether they are actually read
//   branchD                     branch/jr compare happening in D
//   rsE, rtE                    E-stage sources
//   writereg{E,M,W}             destination register per stage
//   regwrite{E,M,W}             destination written per stage
//   memtoreg{E,M}               2'b01 marks a load in that stage
//   div_startE                  divide instruction sitting in E
//   mem_reqM, mem_data_okM      data-memory request from M / completion this cycle
//   exceptM                     exception committed in M
//   forwardaD/bD                00 regfile, 01 E, 10 M, 11 W
//   forwardaE/bE                00 regfile, 10 M, 01 W
//   div_busyE, div_doneE        divider occupying E / completion pulse on last busy cycle
//   stall{F,D,E,M}, flush{F,D,E,M,W}  pipeline register controls

module hazard_ctrl_mc #(
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned DIV_CYCLES = 32,
    parameter int unsigned DIV_CNT_W  = 6
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [REG_AW-1:0] rsD,
    input  logic [REG_AW-1:0] rtD,
    input  logic              use_rsD,
    input  logic              use_rtD,
    input  logic              branchD,
    input  logic [REG_AW-1:0] rsE,
    input  logic [REG_AW-1:0] rtE,
    input  logic [REG_AW-1:0] writeregE,
    input  logic [REG_AW-1:0] writeregM,
    input  logic [REG_AW-1:0] writeregW,
    input  logic              regwriteE,
    input  logic              regwriteM,
    input  logic              regwriteW,
    input  logic [1:0]        memtoregE,
    input  logic [1:0]        memtoregM,
    input  logic              div_startE,
    input  logic              mem_reqM,
    input  logic              mem_data_okM,
    input  logic              exceptM,
    output logic [1:0]        forwardaD,
    output logic [1:0]        forwardbD,
    output logic [1:0]        forwardaE,
    output logic [1:0]        forwardbE,
    output logic              div_busyE,
    output logic              div_doneE,
    output logic              stallF,
    output logic              stallD,
    output logic              stallE,
    output logic              stallM,
    output logic              flushF,
    output logic              flushD,
    output logic              flushE,
    output logic              flushM,
    output logic              flushW
);

    localparam logic [1:0]           MemLoad  = 2'b01;
    localparam logic [DIV_CNT_W-1:0] DivStart = DIV_CNT_W'(DIV_CYCLES - 1);

    typedef enum logic {StIdle, StWait} mem_state_e;

    mem_state_e           mem_state_q, mem_state_d;
    logic [DIV_CNT_W-1:0] div_cnt_q, div_cnt_d;
    logic                 div_done_q, div_done_d;

    logic load_e, load_m;
    logic m_fwd_ok, w_fwd_ok;
    logic lw_stall, br_stall, mem_stall, except_flush, div_start;

    assign load_e   = (memtoregE == MemLoad);
    assign load_m   = (memtoregM == MemLoad);
    // Loads only have data once they reach W, so M forwards ALU results only.
    assign m_fwd_ok = regwriteM & ~load_m & (writeregM != '0);
    assign w_fwd_ok = regwriteW & (writeregW != '0);

`ifdef HAZARD_FWD_E2D_EN
    logic e_fwd_ok;
    assign e_fwd_ok = regwriteE & ~load_e & (writeregE != '0);
`endif

    // Later assignments win, so the nearest producer is written last.
    always_comb begin
        forwardaD = 2'b00;
        forwardbD = 2'b00;
        if (w_fwd_ok && writeregW == rsD) forwardaD = 2'b11;
        if (w_fwd_ok && writeregW == rtD) forwardbD = 2'b11;
        if (m_fwd_ok && writeregM == rsD) forwardaD = 2'b10;
        if (m_fwd_ok && writeregM == rtD) forwardbD = 2'b10;
`ifdef HAZARD_FWD_E2D_EN
        if (e_fwd_ok && writeregE == rsD) forwardaD = 2'b01;
        if (e_fwd_ok && writeregE == rtD) forwardbD = 2'b01;
`endif
    end

    always_comb begin
        forwardaE = 2'b00;
        forwardbE = 2'b00;
        if (w_fwd_ok && writeregW == rsE) forwardaE = 2'b01;
        if (w_fwd_ok && writeregW == rtE) forwardbE = 2'b01;
        if (m_fwd_ok && writeregM == rsE) forwardaE = 2'b10;
        if (m_fwd_ok && writeregM == rtE) forwardbE = 2'b10;
    end

    assign lw_stall = load_e & regwriteE & (writeregE != '0) &
                      ((use_rsD & (writeregE == rsD)) | (use_rtD & (writeregE == rtD)));

`ifdef HAZARD_FWD_E2D_EN
    assign br_stall = branchD & load_m & (writeregM != '0) &
                      ((use_rsD & (writeregM == rsD)) | (use_rtD & (writeregM == rtD)));
`else
    assign br_stall = branchD &
                      ((load_m & (writeregM != '0) &
                        ((use_rsD & (writeregM == rsD)) | (use_rtD & (writeregM == rtD)))) |
                       (regwriteE & (writeregE != '0) &
                        ((use_rsD & (writeregE == rsD)) | (use_rtD & (writeregE == rtD)))));
`endif

    assign mem_stall    = ((mem_state_q == StIdle) & mem_reqM & ~mem_data_okM) |
                          ((mem_state_q == StWait) & ~mem_data_okM);
    // An exception arriving while a memory access is outstanding is not taken.
    assign except_flush = exceptM & (mem_state_q == StIdle);

    // div_done_q blocks a restart while the finished divide is still held in E.
    assign div_start = div_startE & (div_cnt_q == '0) & ~div_done_q & ~except_flush;
    assign div_busyE = div_start | (div_cnt_q != '0);
    assign div_doneE = div_busyE & (div_cnt_q == DIV_CNT_W'(1));

    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        stallM = 1'b0;
        flushF = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        flushM = 1'b0;
        flushW = 1'b0;
        if (except_flush) begin
            flushF = 1'b1;
            flushD = 1'b1;
            flushE = 1'b1;
            flushM = 1'b1;
        end else if (mem_stall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
            flushW = 1'b1;
        end else if (div_busyE) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            flushM = 1'b1;
        end else if (lw_stall || br_stall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1; // E is never stalled on this branch, so a bubble goes in
        end
    end

    always_comb begin
        div_cnt_d  = div_cnt_q;
        div_done_d = div_done_q;
        if (except_flush) begin
            div_cnt_d  = '0;
            div_done_d = 1'b0;
        end else begin
            if (div_start) begin
                div_cnt_d = DivStart;
            end else if (div_cnt_q != '0) begin
                div_cnt_d = div_cnt_q - DIV_CNT_W'(1);
            end
            if (div_doneE) begin
                div_done_d = 1'b1;
            end else if (!stallE) begin
                div_done_d = 1'b0;
            end
        end
    end

    always_comb begin
        mem_state_d = mem_state_q;
        unique case (mem_state_q)
            StIdle:  if (mem_reqM && !mem_data_okM) mem_state_d = StWait;
            StWait:  if (mem_data_okM) mem_state_d = StIdle;
            default: mem_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_state_q <= StIdle;
            div_cnt_q   <= '0;
            div_done_q  <= 1'b0;
        end else begin
            mem_state_q <= mem_state_d;
            div_cnt_q   <= div_cnt_d;
            div_done_q  <= div_done_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
module tb_hazard_ctrl_mc;

    localparam int unsigned DIV_CYCLES = 32;

    logic       clk = 1'b0;
    logic       resetn;
    logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic       use_rsD, use_rtD, branchD, regwriteE, regwriteM, regwriteW;
    logic [1:0] memtoregE, memtoregM;
    logic       div_startE, mem_reqM, mem_data_okM, exceptM;
    logic [1:0] forwardaD, forwardbD, forwardaE, forwardbE;
    logic       div_busyE, div_doneE;
    logic       stallF, stallD, stallE, stallM, flushF, flushD, flushE, flushM, flushW;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: busy cycles still to come, finished-divide hold, memory outstanding.
    int div_rem = 0;
    bit hold = 0;
    bit waiting = 0;
    int div_rem_n;
    bit hold_n, waiting_n;

    logic [18:0] act, exp_v;

    hazard_ctrl_mc #(.REG_AW(5), .DIV_CYCLES(DIV_CYCLES), .DIV_CNT_W(6)) dut (
        .clk(clk), .resetn(resetn),
        .rsD(rsD), .rtD(rtD), .use_rsD(use_rsD), .use_rtD(use_rtD), .branchD(branchD),
        .rsE(rsE), .rtE(rtE),
        .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
        .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .memtoregE(memtoregE), .memtoregM(memtoregM),
        .div_startE(div_startE), .mem_reqM(mem_reqM), .mem_data_okM(mem_data_okM),
        .exceptM(exceptM),
        .forwardaD(forwardaD), .forwardbD(forwardbD),
        .forwardaE(forwardaE), .forwardbE(forwardbE),
        .div_busyE(div_busyE), .div_doneE(div_doneE),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
        .flushF(flushF), .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW)
    );

    always #5 clk = ~clk;

    assign act = {forwardaD, forwardbD, forwardaE, forwardbE, div_busyE, div_doneE,
                  stallF, stallD, stallE, stallM, flushF, flushD, flushE, flushM, flushW};

    function automatic logic [1:0] fwd_d(input logic [4:0] src);
        if (src == 0) return 2'b00;
`ifdef HAZARD_FWD_E2D_EN
        if (regwriteE && memtoregE != 2'b01 && writeregE == src) return 2'b01;
`endif
        if (regwriteM && memtoregM != 2'b01 && writeregM == src) return 2'b10;
        if (regwriteW && writeregW == src) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [1:0] fwd_e(input logic [4:0] src);
        if (src == 0) return 2'b00;
        if (regwriteM && memtoregM != 2'b01 && writeregM == src) return 2'b10;
        if (regwriteW && writeregW == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit d_reads(input logic [4:0] r);
        return r != 0 && ((use_rsD && rsD == r) || (use_rtD && rtD == r));
    endfunction

    task automatic model_eval(output logic [18:0] e);
        bit exc, start, busy, done, mstall, lw, br;
        bit sf, sd, se, sm, ff, fd, fe, fm, fw;
        int rem;
        lw = regwriteE && memtoregE == 2'b01 && d_reads(writeregE);
        br = branchD && memtoregM == 2'b01 && d_reads(writeregM);
`ifndef HAZARD_FWD_E2D_EN
        br = br || (branchD && regwriteE && d_reads(writeregE));
`endif
        exc    = exceptM && !waiting;
        start  = div_startE && div_rem == 0 && !hold && !exc;
        rem    = start ? DIV_CYCLES : div_rem;
        busy   = rem > 0;
        done   = rem == 1;
        mstall = !mem_data_okM && (waiting || mem_reqM);
        {sf, sd, se, sm, ff, fd, fe, fm, fw} = '0;
        if (exc) {ff, fd, fe, fm} = 4'hf;
        else if (mstall) {sf, sd, se, sm, fw} = 5'h1f;
        else if (busy) {sf, sd, se, fm} = 4'hf;
        else if (lw || br) {sf, sd, fe} = 3'h7;
        div_rem_n = exc ? 0 : (busy ? rem - 1 : 0);
        hold_n    = exc ? 1'b0 : (done ? 1'b1 : (!se ? 1'b0 : hold));
        waiting_n = waiting ? !mem_data_okM : (mem_reqM && !mem_data_okM);
        e = {fwd_d(rsD), fwd_d(rtD), fwd_e(rsE), fwd_e(rtE), busy, done,
             sf, sd, se, sm, ff, fd, fe, fm, fw};
    endtask

    task automatic model_reset();
        div_rem = 0;
        hold    = 0;
        waiting = 0;
    endtask

    task automatic tick();
        logic [18:0] dummy;
        model_eval(dummy);
        @(posedge clk);
        #1;
        if (!resetn) model_reset();
        else begin
            div_rem = div_rem_n;
            hold    = hold_n;
            waiting = waiting_n;
        end
    endtask

    task automatic clear_inputs();
        {rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW} = '0;
        {use_rsD, use_rtD, branchD, regwriteE, regwriteM, regwriteW} = '0;
        memtoregE = 2'b00;
        memtoregM = 2'b00;
        {div_startE, mem_reqM, mem_data_okM, exceptM} = '0;
    endtask

    task automatic random_regs();
        rsD = 5'($urandom_range(0, 3));
        rtD = 5'($urandom_range(0, 3));
        rsE = 5'($urandom_range(0, 3));
        rtE = 5'($urandom_range(0, 3));
        writeregE = 5'($urandom_range(0, 3));
        writeregM = 5'($urandom_range(0, 3));
        writeregW = 5'($urandom_range(0, 3));
        {use_rsD, use_rtD, branchD} = 3'($urandom);
        {regwriteE, regwriteM, regwriteW} = 3'($urandom);
        memtoregE = 2'($urandom);
        memtoregM = 2'($urandom);
    endtask

    task automatic test_reset();
        clear_inputs();
        resetn = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            if (i == 2) resetn = 1'b1;
            #4;
            model_eval(exp_v);
            n_checks++;
            if (act !== exp_v || act !== 19'h0) begin
                n_fail++;
                $display("FAIL reset cyc %0d: got %b want %b", i, act, exp_v);
            end
            tick();
        end
    endtask

    task automatic test_forwarding();
        for (int s = 0; s < 7; s++) begin
            clear_inputs();
            case (s)
                0: begin // lw r2 in E, D reads r2
                    regwriteE = 1; memtoregE = 2'b01; writeregE = 2; use_rsD = 1; rsD = 2;
                end
                1: begin // lw now in M, bubble in E
                    regwriteM = 1; memtoregM = 2'b01; writeregM = 2; use_rsD = 1; rsD = 2;
                end
                2: begin regwriteW = 1; writeregW = 2; rsE = 2; end
                3: begin regwriteM = 1; writeregM = 3; regwriteW = 1; writeregW = 3; rsE = 3; end
                4: begin regwriteW = 1; writeregW = 3; rtE = 3; rtD = 3; end
                5: begin regwriteM = 1; regwriteW = 1; rsE = 0; rsD = 0; end
                default: begin // beq r4 after add r4 in E
                    regwriteE = 1; writeregE = 4; branchD = 1; use_rsD = 1; rsD = 4;
                end
            endcase
            #4;
            model_eval(exp_v);
            n_checks++;
            if (act !== exp_v) begin
                n_fail++;
                $display("FAIL fwd_directed step %0d: got %b want %b", s, act, exp_v);
            end
            tick();
        end
        for (int i = 0; i < 200; i++) begin
            clear_inputs();
            random_regs();
            #4;
            model_eval(exp_v);
            n_checks++;
            if (act !== exp_v) begin
                n_fail++;
                $display("FAIL fwd_random cyc %0d: got %b want %b", i, act, exp_v);
            end
            tick();
        end
    endtask

    task automatic test_div();
        for (int i = 0; i < 40; i++) begin
            clear_inputs();
            div_startE   = (i <= 34);           // divide held in E until it can leave
            mem_reqM     = (i >= 30 && i <= 34);
            mem_data_okM = (i == 34);
            #4;
            model_eval(exp_v);
            n_checks++;
            if (act !== exp_v) begin
                n_fail++;
                $display("FAIL div cyc %0d: got %b want %b", i, act, exp_v);
            end
            tick();
        end
    endtask

    task automatic test_mem();
        for (int i = 0; i < 8; i++) begin
            clear_inputs();
            mem_reqM     = (i <= 3) || (i == 5);
            mem_data_okM = (i == 3) || (i == 5);
            #4;
            model_eval(exp_v);
            n_checks++;
            if (act !== exp_v) begin
                n_fail++;
                $display("FAIL mem cyc %0d: got %b want %b", i, act, exp_v);
            end
            tick();
        end
    endtask

    task automatic test_except();
        for (int i = 0; i < 32; i++) begin
            clear_inputs();
            div_startE   = (i <= 22);
            exceptM      = (i == 22) || (i == 27);
            mem_reqM     = (i >= 26 && i <= 28);   // exception at 27 lands in WAIT
            mem_data_okM = (i == 28);
            #4;
            model_eval(exp_v);
            n_checks++;
            if (act !== exp_v) begin
                n_fail++;
                $display("FAIL except cyc %0d: got %b want %b", i, act, exp_v);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 6; i++) begin
            clear_inputs();
            mem_reqM = (i < 2);
            #4;
            if (i == 2) begin
                resetn = 1'b0;
                model_reset();
                #1;
            end
            if (i == 4) resetn = 1'b1;
            model_eval(exp_v);
            n_checks++;
            if (act !== exp_v) begin
                n_fail++;
                $display("FAIL reset_mid cyc %0d: got %b want %b", i, act, exp_v);
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            clear_inputs();
            random_regs();
            div_startE   = ($urandom_range(0, 7) == 0);
            mem_reqM     = ($urandom_range(0, 3) == 0);
            mem_data_okM = ($urandom_range(0, 1) == 0);
            exceptM      = ($urandom_range(0, 19) == 0);
            #4;
            model_eval(exp_v);
            n_checks++;
            if (act !== exp_v) begin
                n_fail++;
                $display("FAIL random cyc %0d: got %b want %b", i, act, exp_v);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_div();
        test_mem();
        test_except();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
